// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timer_pkg
//  Description : Shared definitions for the egg countdown timer.
//                - state_t     : FSM state encoding (IDLE, RUN, PAUSE, EXPIRED)
//                - c_max_ones  : wrap value of a ones digit on borrow
//                - c_max_tens  : wrap value of the seconds-tens digit on borrow
//                - c_zero_time : BCD MM:SS value meaning "time is up"
//  Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    localparam logic [3:0]  c_max_ones  = 4'h9;
    localparam logic [3:0]  c_max_tens  = 4'h5;
    localparam logic [15:0] c_zero_time = 16'h0000;

endpackage : timer_pkg
`default_nettype wire

// File: rtl/egg_countdown_if.sv
`default_nettype none
// ============================================================================
//  Module      : egg_countdown_if
//  Description : Control/status bundle of the egg countdown timer.
//                master : drives validTime, load, start, stop, ack, tick;
//                         observes timeLeft, running, alarm
//                slave  : the timer itself (mirror directions)
//  Revision    : 1.0 - initial release
// ============================================================================
interface egg_countdown_if;

    logic [15:0] validTime;   // BCD MM:SS preset
    logic        load;        // pulse: copy preset into the countdown
    logic        start;       // pulse: begin/resume counting
    logic        stop;        // pulse: pause counting
    logic        ack;         // pulse: silence the alarm
    logic        tick;        // 1 Hz enable (unused with TICK_GEN_EN)
    logic [15:0] timeLeft;    // BCD MM:SS remaining
    logic        running;     // high in RUN
    logic        alarm;       // high in EXPIRED

    modport master (
        output validTime, load, start, stop, ack, tick,
        input  timeLeft, running, alarm
    );

    modport slave (
        input  validTime, load, start, stop, ack, tick,
        output timeLeft, running, alarm
    );

endinterface : egg_countdown_if
`default_nettype wire

// File: rtl/bcd_digit_dec.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_dec
//  Description : One BCD digit of a borrow-chained decrementer.
//                digit_i  : current digit value
//                max_i    : value the digit wraps to when it borrows
//                borrow_i : decrement request from the lower digit
//                digit_o  : resulting digit
//                borrow_o : decrement request to the next higher digit
//                Values above max_i are decremented plainly (no clamping).
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_dec (
    input  logic [3:0] digit_i,
    input  logic [3:0] max_i,
    input  logic       borrow_i,
    output logic [3:0] digit_o,
    output logic       borrow_o
);

    always_comb begin
        digit_o  = digit_i;
        borrow_o = 1'b0;
        if (borrow_i) begin
            if (digit_i == 4'h0) begin
                digit_o  = max_i;
                borrow_o = 1'b1;
            end else begin
                digit_o  = digit_i - 4'h1;
            end
        end
    end

endmodule : bcd_digit_dec
`default_nettype wire

// File: rtl/egg_countdown.sv
`default_nettype none
// ============================================================================
//  Module      : egg_countdown
//  Description : BCD MM:SS kitchen countdown timer with pause and alarm.
//                clk   : system clock, rising edge
//                rst_n : synchronous active-low reset
//                bus   : egg_countdown_if.slave (preset, control pulses,
//                        tick, timeLeft/running/alarm status)
//                Option macro TICK_GEN_EN: derive the 1 Hz tick internally
//                from a CLK_DIV prescaler that only counts in RUN; the tick
//                input is then ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module egg_countdown
    import timer_pkg::*;
#(
    parameter int unsigned CLK_DIV = 50000000
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    egg_countdown_if.slave  bus
);

    state_t      state_q, state_d;
    logic [15:0] time_q, time_d;
    logic        running_q, alarm_q;

    logic        w_tick;
    logic [15:0] w_time_dec;
    logic [4:0]  w_borrow;

    // ------------------------------------------------------------------
    // Tick source
    // ------------------------------------------------------------------
`ifdef TICK_GEN_EN
    localparam int              c_cnt_w    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CLK_DIV - 1);

    logic [c_cnt_w-1:0] presc_q, presc_d;

    // Held at zero outside RUN so every start/resume waits a full period.
    always_comb begin
        presc_d = presc_q;
        if (state_q != ST_RUN) begin
            presc_d = '0;
        end else if (presc_q == c_cnt_last) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + c_cnt_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    assign w_tick = (state_q == ST_RUN) && (presc_q == c_cnt_last);

    wire w_unused_tick = bus.tick;
`else
    assign w_tick = bus.tick;

    localparam int unsigned c_unused_clk_div = CLK_DIV;
`endif

    // ------------------------------------------------------------------
    // One-second BCD decrement: sec ones, sec tens, min ones, min tens.
    // The min-tens wrap value is never reached because zero time leaves RUN.
    // ------------------------------------------------------------------
    assign w_borrow[0] = 1'b1;

    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
        bcd_digit_dec u_dec (
            .digit_i  (time_q[gi*4 +: 4]),
            .max_i    ((gi == 1) ? c_max_tens : c_max_ones),
            .borrow_i (w_borrow[gi]),
            .digit_o  (w_time_dec[gi*4 +: 4]),
            .borrow_o (w_borrow[gi+1])
        );
    end

    wire w_unused_borrow = w_borrow[4];

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        case (state_q)
            ST_IDLE, ST_PAUSE: begin
                if (bus.load) begin
                    time_d  = bus.validTime;
                    state_d = ST_IDLE;
                end else if (bus.start && (time_q != c_zero_time)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.stop) begin
                    state_d = ST_PAUSE;
                end else if (w_tick) begin
                    time_d = w_time_dec;
                    if (w_time_dec == c_zero_time) begin
                        state_d = ST_EXPIRED;
                    end
                end
            end
            ST_EXPIRED: begin
                if (bus.load) begin
                    time_d  = bus.validTime;
                    state_d = ST_IDLE;
                end else if (bus.ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next state so they line up
    // with state_q.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            time_q    <= c_zero_time;
            running_q <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            time_q    <= time_d;
            running_q <= (state_d == ST_RUN);
            alarm_q   <= (state_d == ST_EXPIRED);
        end
    end

    assign bus.timeLeft = time_q;
    assign bus.running  = running_q;
    assign bus.alarm    = alarm_q;

endmodule : egg_countdown
`default_nettype wire

// File: tb/tb_egg_countdown.sv
`default_nettype none
// ============================================================================
//  Module      : tb_egg_countdown
//  Description : Self-checking bench for egg_countdown. A behavioural model
//                keeps the remaining time as plain seconds plus two mode
//                flags; directed scenarios and a randomized run compare the
//                DUT against it or against fixed expectations.
//                Build with TICK_GEN_EN to exercise the internal prescaler
//                (CLK_DIV = 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_egg_countdown;

    logic clk;
    logic rst_n;

    egg_countdown_if bus ();

    egg_countdown #(.CLK_DIV(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: time in seconds, mode flags.
    int m_secs;
    bit m_run;
    bit m_exp;

    function automatic int to_secs(input logic [15:0] b);
        return ((int'(b[15:12]) * 10 + int'(b[11:8])) * 60)
               + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [15:0] to_bcd(input int s);
        int mm, ss;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic model_update(input logic ld, st, sp, ak, tk,
                                input logic [15:0] vt);
        if (m_run) begin
            if (sp) begin
                m_run = 1'b0;
            end else if (tk) begin
                m_secs = m_secs - 1;
                if (m_secs == 0) begin
                    m_run = 1'b0;
                    m_exp = 1'b1;
                end
            end
        end else if (ld) begin
            m_secs = to_secs(vt);
            m_exp  = 1'b0;
        end else if (m_exp) begin
            if (ak) m_exp = 1'b0;
        end else if (st && m_secs != 0) begin
            m_run = 1'b1;
        end
    endtask

    // Apply one clock cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic ld, st, sp, ak, tk, input logic [15:0] vt);
        bus.validTime = vt;
        bus.load  = ld;
        bus.start = st;
        bus.stop  = sp;
        bus.ack   = ak;
        bus.tick  = tk;
        @(posedge clk);
        #1;
        bus.load  = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.ack   = 1'b0;
        bus.tick  = 1'b0;
        model_update(ld, st, sp, ak, tk, vt);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(0, 0, 0, 0, 0, 16'h0000);
        rst_n = 1'b1;
        m_secs = 0;
        m_run  = 1'b0;
        m_exp  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (bus.timeLeft !== 16'h0000) begin
            n_errors++;
            $display("FAIL reset_time: got %h expected %h", bus.timeLeft, 16'h0000);
        end
        n_checks++;
        if (bus.running !== 1'b0 || bus.alarm !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_flags: got running=%b alarm=%b expected 0/0",
                     bus.running, bus.alarm);
        end
    endtask

    task automatic test_load_run();
        do_reset();
        step(1, 0, 0, 0, 0, 16'h0102);
        n_checks++;
        if (bus.timeLeft !== 16'h0102 || bus.running !== 1'b0) begin
            n_errors++;
            $display("FAIL load: got %h running=%b expected 0102 running=0",
                     bus.timeLeft, bus.running);
        end
        step(0, 1, 0, 0, 0, 16'h0000);
        step(0, 0, 0, 0, 1, 16'h0000);
        step(0, 0, 0, 0, 1, 16'h0000);
        n_checks++;
        if (bus.timeLeft !== 16'h0100 || bus.running !== 1'b1) begin
            n_errors++;
            $display("FAIL run_2ticks: got %h running=%b expected 0100 running=1",
                     bus.timeLeft, bus.running);
        end
    endtask

    task automatic test_borrow();
        logic [15:0] pre [5]  = '{16'h1000, 16'h0100, 16'h0010, 16'h0123, 16'h2000};
        logic [15:0] post [5] = '{16'h0959, 16'h0059, 16'h0009, 16'h0122, 16'h1959};
        for (int i = 0; i < 5; i++) begin
            do_reset();
            step(1, 0, 0, 0, 0, pre[i]);
            step(0, 1, 0, 0, 0, 16'h0000);
            step(0, 0, 0, 0, 1, 16'h0000);
            n_checks++;
            if (bus.timeLeft !== post[i]) begin
                n_errors++;
                $display("FAIL borrow_%h: got %h expected %h", pre[i], bus.timeLeft, post[i]);
            end
        end
    endtask

    task automatic test_expire();
        do_reset();
        step(1, 0, 0, 0, 0, 16'h0001);
        step(0, 1, 0, 0, 0, 16'h0000);
        step(0, 0, 0, 0, 1, 16'h0000);
        n_checks++;
        if (bus.timeLeft !== 16'h0000 || bus.alarm !== 1'b1 || bus.running !== 1'b0) begin
            n_errors++;
            $display("FAIL expire: got %h alarm=%b running=%b expected 0000 1 0",
                     bus.timeLeft, bus.alarm, bus.running);
        end
        step(0, 1, 0, 0, 1, 16'h0000);
        n_checks++;
        if (bus.alarm !== 1'b1 || bus.running !== 1'b0) begin
            n_errors++;
            $display("FAIL expired_hold: got alarm=%b running=%b expected 1 0",
                     bus.alarm, bus.running);
        end
        step(0, 0, 0, 1, 0, 16'h0000);
        n_checks++;
        if (bus.alarm !== 1'b0 || bus.timeLeft !== 16'h0000) begin
            n_errors++;
            $display("FAIL ack: got alarm=%b time=%h expected 0 0000", bus.alarm, bus.timeLeft);
        end
        step(0, 1, 0, 0, 0, 16'h0000);
        n_checks++;
        if (bus.running !== 1'b0) begin
            n_errors++;
            $display("FAIL start_zero: got running=%b expected 0", bus.running);
        end
        // load wins over ack in EXPIRED
        step(1, 0, 0, 0, 0, 16'h0001);
        step(0, 1, 0, 0, 0, 16'h0000);
        step(0, 0, 0, 0, 1, 16'h0000);
        step(1, 0, 0, 1, 0, 16'h0042);
        n_checks++;
        if (bus.timeLeft !== 16'h0042 || bus.alarm !== 1'b0) begin
            n_errors++;
            $display("FAIL load_over_ack: got %h alarm=%b expected 0042 0",
                     bus.timeLeft, bus.alarm);
        end
    endtask

    task automatic test_stop_tick();
        do_reset();
        step(1, 0, 0, 0, 0, 16'h0030);
        step(1, 1, 0, 0, 0, 16'h0030);
        n_checks++;
        if (bus.running !== 1'b0) begin
            n_errors++;
            $display("FAIL load_over_start: got running=%b expected 0", bus.running);
        end
        step(0, 1, 0, 0, 0, 16'h0000);
        step(0, 0, 1, 0, 1, 16'h0000);
        n_checks++;
        if (bus.timeLeft !== 16'h0030 || bus.running !== 1'b0) begin
            n_errors++;
            $display("FAIL stop_over_tick: got %h running=%b expected 0030 0",
                     bus.timeLeft, bus.running);
        end
        step(0, 0, 0, 0, 1, 16'h0000);
        n_checks++;
        if (bus.timeLeft !== 16'h0030) begin
            n_errors++;
            $display("FAIL pause_tick: got %h expected 0030", bus.timeLeft);
        end
        step(0, 1, 0, 0, 0, 16'h0000);
        step(1, 0, 0, 0, 1, 16'h0999);
        n_checks++;
        if (bus.timeLeft !== 16'h0029 || bus.running !== 1'b1) begin
            n_errors++;
            $display("FAIL load_in_run: got %h running=%b expected 0029 1",
                     bus.timeLeft, bus.running);
        end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        step(1, 0, 0, 0, 0, 16'h0530);
        step(0, 1, 0, 0, 0, 16'h0000);
        rst_n = 1'b0;
        step(0, 0, 0, 0, 1, 16'h0000);
        rst_n = 1'b1;
        n_checks++;
        if (bus.timeLeft !== 16'h0000 || bus.running !== 1'b0 || bus.alarm !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_run: got %h running=%b alarm=%b expected 0000 0 0",
                     bus.timeLeft, bus.running, bus.alarm);
        end
        step(1, 0, 0, 0, 0, 16'h0001);
        step(0, 1, 0, 0, 0, 16'h0000);
        step(0, 0, 0, 0, 1, 16'h0000);
        rst_n = 1'b0;
        step(0, 0, 0, 0, 0, 16'h0000);
        rst_n = 1'b1;
        step(0, 0, 0, 0, 1, 16'h0000);
        n_checks++;
        if (bus.alarm !== 1'b0 || bus.running !== 1'b0 || bus.timeLeft !== 16'h0000) begin
            n_errors++;
            $display("FAIL reset_expired: got %h running=%b alarm=%b expected 0000 0 0",
                     bus.timeLeft, bus.running, bus.alarm);
        end
    endtask

    task automatic test_random();
        logic ld, st, sp, ak, tk;
        logic [15:0] vt;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            ld = ($urandom_range(0, 99) < 6);
            st = ($urandom_range(0, 99) < 25);
            sp = ($urandom_range(0, 99) < 5);
            ak = ($urandom_range(0, 99) < 15);
            tk = ($urandom_range(0, 99) < 60);
            vt = ($urandom_range(0, 1) == 0) ? to_bcd(int'($urandom_range(0, 15)))
                                             : to_bcd(int'($urandom_range(0, 5999)));
            step(ld, st, sp, ak, tk, vt);
            n_checks++;
            if (bus.timeLeft !== to_bcd(m_secs) || bus.running !== m_run
                || bus.alarm !== m_exp) begin
                n_errors++;
                $display("FAIL random_%0d: got %h run=%b alarm=%b expected %h run=%b alarm=%b",
                         i, bus.timeLeft, bus.running, bus.alarm,
                         to_bcd(m_secs), m_run, m_exp);
            end
        end
    endtask

    task automatic test_prescaler();
        logic [15:0] exp_t;
        do_reset();
        step(1, 0, 0, 0, 1, 16'h0002);
        step(0, 1, 0, 0, 1, 16'h0000);
        for (int k = 1; k <= 8; k++) begin
            step(0, 0, 0, 0, 1, 16'h0000);
            exp_t = (k < 4) ? 16'h0002 : (k < 8) ? 16'h0001 : 16'h0000;
            n_checks++;
            if (bus.timeLeft !== exp_t || bus.running !== (k < 8) || bus.alarm !== (k == 8)) begin
                n_errors++;
                $display("FAIL presc_clk%0d: got %h run=%b alarm=%b expected %h run=%b alarm=%b",
                         k, bus.timeLeft, bus.running, bus.alarm, exp_t, (k < 8), (k == 8));
            end
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.validTime = 16'h0000;
        bus.load      = 1'b0;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.ack       = 1'b0;
        bus.tick      = 1'b0;
        m_secs        = 0;
        m_run         = 1'b0;
        m_exp         = 1'b0;
        #2;
        test_reset();
`ifdef TICK_GEN_EN
        test_prescaler();
`else
        test_load_run();
        test_borrow();
        test_expire();
        test_stop_tick();
        test_reset_mid_run();
        test_random();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_egg_countdown
`default_nettype wire

// File: doc/egg_countdown.md
EGG_COUNTDOWN -- requirements
Module: egg_countdown

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50000000, clk cycles per one-second tick (used only with TICK_GEN_EN).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port validTime  input  16  BCD MM:SS preset from the upstream switch validator: [15:12] min tens, [11:8] min ones, [7:4] sec tens, [3:0] sec ones.
REQ-005 SHALL have port load  input  1  single-cycle pulse; copies validTime into the countdown register.
REQ-006 SHALL have port start  input  1  single-cycle pulse; begin or resume counting.
REQ-007 SHALL have port stop  input  1  single-cycle pulse; pause counting.
REQ-008 SHALL have port ack  input  1  single-cycle pulse; silences the alarm.
REQ-009 SHALL have port tick  input  1  one-clk-wide 1 Hz enable (ignored when TICK_GEN_EN is defined).
REQ-010 SHALL have port timeLeft  output  16  current remaining time, BCD, same digit layout as validTime.
REQ-011 SHALL have port running  output  1  high while in RUN.
REQ-012 SHALL have port alarm  output  1  high while in EXPIRED.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, PAUSE, EXPIRED; outputs registered.
REQ-014 SHALL, in IDLE/PAUSE/EXPIRED, on load: timeLeft <= validTime next cycle; state -> IDLE.
REQ-015 SHALL ignore load while in RUN.
REQ-016 SHALL, in IDLE/PAUSE, on start with timeLeft != 16'h0000: -> RUN; with timeLeft == 0: stay in current state.
REQ-017 SHALL, in RUN, on stop: -> PAUSE, timeLeft frozen.
REQ-018 SHALL, in RUN, on tick without stop: decrement timeLeft by one second in BCD, result visible next cycle.
REQ-019 SHALL borrow as follows: sec ones 0 -> 9 with borrow; sec tens 0 -> 5 with borrow; min ones 0 -> 9 with borrow; min tens decremented; a non-borrowing digit simply decrements by 1.
REQ-020 SHALL, when a decrement produces 16'h0000: -> EXPIRED in the same update; alarm high on the following cycle.
REQ-021 SHALL, in EXPIRED, on ack: -> IDLE, timeLeft stays 16'h0000; on load: per REQ-014.
REQ-022 SHALL resolve simultaneous events with priority: stop > tick in RUN (no decrement); load > start in IDLE/PAUSE/EXPIRED (start dropped); in EXPIRED, load > ack.
REQ-023 SHALL ignore start, ack and tick in every state not listed above.
REQ-024 SHALL treat digit values above their maximum (only possible if the preset is invalid) by plain decrement, with no clamping.

Reset
REQ-025 SHALL, while rst_n is low at a rising edge: state IDLE, timeLeft 16'h0000, running 0, alarm 0, prescaler 0.
REQ-026 SHALL apply reset mid-RUN or mid-EXPIRED identically, with no residual tick or alarm.

Configuration
REQ-027 SHALL, with TICK_GEN_EN defined, derive tick internally: counter 0..CLK_DIV-1, enabled only in RUN, cleared outside RUN, tick on terminal count; the first decrement after start follows exactly CLK_DIV cycles later; the tick port is ignored.
REQ-028 SHALL, without TICK_GEN_EN, use the tick port directly and contain no prescaler logic.

Structure
REQ-029 SHALL take the FSM state enum, digit maxima (4'h9, 4'h5) and the zero-time constant from the shared package timer_pkg.
REQ-030 SHALL use one sub-module bcd_digit_dec (digit in, max value, borrow in -> digit out, borrow out), instantiated four times in a chain.

Verification
REQ-031 SHALL cover: validTime=16'h0102, load, start, 2 ticks -> timeLeft 16'h0100, running=1.
REQ-032 SHALL cover: timeLeft 16'h1000 in RUN, tick -> 16'h0959.
REQ-033 SHALL cover: timeLeft 16'h0001 in RUN, tick -> 16'h0000, alarm=1 next cycle, running=0; ack -> IDLE, alarm=0.
REQ-034 SHALL cover: in RUN, stop and tick in the same cycle -> PAUSE, timeLeft unchanged; start in IDLE with timeLeft 0 -> remains IDLE.
REQ-035 SHALL cover: rst_n low during RUN at 16'h0530 -> next cycle timeLeft 16'h0000, running 0, alarm 0.
REQ-036 SHALL cover, with TICK_GEN_EN and CLK_DIV=4: start at 16'h0002 -> 16'h0001 exactly 4 clk after start, 16'h0000 and EXPIRED after 8.
